dsp_post_acc: RTL and testbench

DSP_POST_ACC -- requirements
Module: dsp_post_acc

---
 rtl/dsp_pkg.sv | 28 ++
 rtl/reg_mul.sv | 45 ++++
 rtl/dsp_post_acc.sv | 100 ++++++++++
 tb/tb_dsp_post_acc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants for the DSP post-adder slice: opmode field layout,
// X/Z mux encodings and operand widths.
package dsp_pkg;

    localparam int P_W   = 48;
    localparam int M_W   = 36;
    localparam int OPM_W = 5;

    localparam int OPM_X_LSB   = 0;
    localparam int OPM_Z_LSB   = 2;
    localparam int OPM_SUB_BIT = 4;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    // Sign-extend the 36-bit multiplier product onto the 48-bit datapath.
    function automatic logic [P_W-1:0] sext_m(input logic [M_W-1:0] m);
        return {{(P_W-M_W){m[M_W-1]}}, m};
    endfunction

endpackage

// File: rtl/reg_mul.sv
// Configurable pipeline register: optional (REG), with clock enable and
// either asynchronous or synchronous active-high reset.
module reg_mul #(
    parameter int    WIDTH   = 1,
    parameter int    REG     = 1,
    parameter string RSTtype = "ASYNC"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (REG == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = ^{clk, rst, ce};
            assign q = d;
        end else if (RSTtype == "ASYNC") begin : g_async
            logic [WIDTH-1:0] q_r;
            // Register with asynchronous clear; enable low holds the value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_r <= {WIDTH{1'b0}};
                end else if (ce) begin
                    q_r <= d;
                end
            end
            assign q = q_r;
        end else begin : g_sync
            logic [WIDTH-1:0] q_r;
            // Register with synchronous clear; enable low holds the value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_r <= {WIDTH{1'b0}};
                end else if (ce) begin
                    q_r <= d;
                end
            end
            assign q = q_r;
        end
    endgenerate

endmodule

// File: rtl/dsp_post_acc.sv
// DSP post-adder/accumulator: X/Z operand muxes feeding a 49-bit add/subtract,
// with optional opmode, carry-in and P/carryout pipeline registers.
module dsp_post_acc
    import dsp_pkg::*;
#(
    parameter int PREG       = 1,
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_p,
    input  logic             ce_opmode,
    input  logic             ce_carryin,
    input  logic [OPM_W-1:0] opmode,
    input  logic             carryin,
    input  logic [M_W-1:0]   m_in,
    input  logic [P_W-1:0]   dab_in,
    input  logic [P_W-1:0]   c_in,
    input  logic [P_W-1:0]   pcin,
    output logic [P_W-1:0]   p,
    output logic [P_W-1:0]   pcout,
    output logic             carryout,
    output logic             carryoutf
);

    logic [OPM_W-1:0] opmode_r;
    logic             carryin_r;
    logic [P_W-1:0]   p_r;
    logic             carryout_r;
    logic [P_W-1:0]   p_fb_s;
    logic [P_W-1:0]   x_s;
    logic [P_W-1:0]   z_s;
    logic [P_W:0]     result_s;

    reg_mul #(.WIDTH(OPM_W), .REG(OPMODEREG), .RSTtype("ASYNC")) u_opmode_reg (
        .clk(clk), .rst(rst), .ce(ce_opmode), .d(opmode), .q(opmode_r)
    );

    reg_mul #(.WIDTH(1), .REG(CARRYINREG), .RSTtype("ASYNC")) u_carryin_reg (
        .clk(clk), .rst(rst), .ce(ce_carryin), .d(carryin), .q(carryin_r)
    );

    // Without a P register the feedback path is tied off to break the loop.
    generate
        if (PREG != 0) begin : g_fb
            assign p_fb_s = p_r;
        end else begin : g_no_fb
            assign p_fb_s = {P_W{1'b0}};
        end
    endgenerate

    // X operand select.
    always_comb begin
        x_s = {P_W{1'b0}};
        case (opmode_r[OPM_X_LSB +: 2])
            X_ZERO:  x_s = {P_W{1'b0}};
            X_M:     x_s = sext_m(m_in);
            X_P:     x_s = p_fb_s;
            X_DAB:   x_s = dab_in;
            default: x_s = {P_W{1'b0}};
        endcase
    end

    // Z operand select.
    always_comb begin
        z_s = {P_W{1'b0}};
        case (opmode_r[OPM_Z_LSB +: 2])
            Z_ZERO:  z_s = {P_W{1'b0}};
            Z_PCIN:  z_s = pcin;
            Z_P:     z_s = p_fb_s;
            Z_C:     z_s = c_in;
            default: z_s = {P_W{1'b0}};
        endcase
    end

    // 49-bit post-adder; bit 48 is the carry (or borrow when subtracting).
    always_comb begin
        result_s = {(P_W+1){1'b0}};
        if (opmode_r[OPM_SUB_BIT]) begin
            result_s = {1'b0, z_s} - ({1'b0, x_s} + {{P_W{1'b0}}, carryin_r});
        end else begin
            result_s = {1'b0, z_s} + {1'b0, x_s} + {{P_W{1'b0}}, carryin_r};
        end
    end

    reg_mul #(.WIDTH(P_W), .REG(PREG), .RSTtype("ASYNC")) u_p_reg (
        .clk(clk), .rst(rst), .ce(ce_p), .d(result_s[P_W-1:0]), .q(p_r)
    );

    reg_mul #(.WIDTH(1), .REG(PREG), .RSTtype("ASYNC")) u_carryout_reg (
        .clk(clk), .rst(rst), .ce(ce_p), .d(result_s[P_W]), .q(carryout_r)
    );

    assign p         = p_r;
    assign pcout     = p_r;
    assign carryout  = carryout_r;
    assign carryoutf = carryout_r;

endmodule

// File: tb/tb_dsp_post_acc.sv
// Directed, table-driven bench for dsp_post_acc: a default-parameter instance
// plus a PREG=0 instance sharing the same stimulus.
module tb_dsp_post_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_p, ce_opmode, ce_carryin;
    logic [4:0]  opmode;
    logic        carryin;
    logic [35:0] m_in;
    logic [47:0] dab_in, c_in, pcin;

    logic [47:0] p1, pcout1, p0, pcout0;
    logic        co1, cof1, co0, cof0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [4:0]  opmode;
        logic        cin;
        logic [35:0] m;
        logic [47:0] dab;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] exp_p;
        logic        exp_co;
    } vec_t;

    vec_t vecs [6];

    dsp_post_acc dut (
        .clk(clk), .rst(rst), .ce_p(ce_p), .ce_opmode(ce_opmode),
        .ce_carryin(ce_carryin), .opmode(opmode), .carryin(carryin),
        .m_in(m_in), .dab_in(dab_in), .c_in(c_in), .pcin(pcin),
        .p(p1), .pcout(pcout1), .carryout(co1), .carryoutf(cof1)
    );

    dsp_post_acc #(.PREG(0)) dut0 (
        .clk(clk), .rst(rst), .ce_p(ce_p), .ce_opmode(ce_opmode),
        .ce_carryin(ce_carryin), .opmode(opmode), .carryin(carryin),
        .m_in(m_in), .dab_in(dab_in), .c_in(c_in), .pcin(pcin),
        .p(p0), .pcout(pcout0), .carryout(co0), .carryoutf(cof0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic [47:0] exp_p, input logic exp_co);
        n_checks++;
        if (p1 !== exp_p || pcout1 !== exp_p || co1 !== exp_co || cof1 !== exp_co) begin
            n_fail++;
            $display("FAIL %s: p=%h pcout=%h co=%b cof=%b, expected p=pcout=%h co=cof=%b",
                     name, p1, pcout1, co1, cof1, exp_p, exp_co);
        end
    endtask

    task automatic check0(input string name, input logic [47:0] exp_p, input logic exp_co);
        n_checks++;
        if (p0 !== exp_p || pcout0 !== exp_p || co0 !== exp_co || cof0 !== exp_co) begin
            n_fail++;
            $display("FAIL %s(PREG=0): p=%h pcout=%h co=%b cof=%b, expected p=pcout=%h co=cof=%b",
                     name, p0, pcout0, co0, cof0, exp_p, exp_co);
        end
    endtask

    initial begin
        vecs[0] = '{"sub_c_dab",   5'b11111, 1'b1, 36'd0, 48'd4, 48'd10, 48'd0, 48'd5, 1'b0};
        vecs[1] = '{"add_wrap",    5'b01111, 1'b0, 36'd0, 48'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b1};
        vecs[2] = '{"neg_m",       5'b00001, 1'b0, 36'hF_FFFF_FFFE, 48'd0, 48'd0, 48'd0, 48'hFFFF_FFFF_FFFE, 1'b0};
        vecs[3] = '{"pcin_cin",    5'b00100, 1'b1, 36'd0, 48'd0, 48'd0, 48'd123, 48'd124, 1'b0};
        vecs[4] = '{"sub_borrow",  5'b11111, 1'b0, 36'd0, 48'd5, 48'd3, 48'd0, 48'hFFFF_FFFF_FFFE, 1'b1};
        vecs[5] = '{"maxpos_m_c",  5'b01101, 1'b0, 36'h7_FFFF_FFFF, 48'd0, 48'd1, 48'd0, 48'h0008_0000_0000, 1'b0};

        rst = 1'b1; ce_p = 1'b1; ce_opmode = 1'b1; ce_carryin = 1'b1;
        opmode = 5'd0; carryin = 1'b0; m_in = 36'd0;
        dab_in = 48'd0; c_in = 48'd0; pcin = 48'd0;

        #2;
        check1("reset_initial", 48'd0, 1'b0);
        check0("reset_initial", 48'd0, 1'b0);

        // Reset held across an edge with every enable high and nonzero operands.
        opmode = 5'b01111; c_in = 48'd7; dab_in = 48'd9; carryin = 1'b1;
        tick();
        check1("reset_wins", 48'd0, 1'b0);
        check0("reset_wins", 48'd0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            opmode = vecs[i].opmode; carryin = vecs[i].cin; m_in = vecs[i].m;
            dab_in = vecs[i].dab; c_in = vecs[i].c; pcin = vecs[i].pcin;
            tick();
            tick();
            check1(vecs[i].name, vecs[i].exp_p, vecs[i].exp_co);
            check0(vecs[i].name, vecs[i].exp_p, vecs[i].exp_co);
        end

        // Accumulate 3 per cycle from a freshly cleared P.
        rst = 1'b1; #1; rst = 1'b0;
        opmode = 5'b01001; m_in = 36'd3; carryin = 1'b0;
        dab_in = 48'd0; c_in = 48'd0; pcin = 48'd0;
        ce_p = 1'b0;
        tick();
        check1("acc_preload", 48'd0, 1'b0);
        check0("acc_fb_zero", 48'd3, 1'b0);
        ce_p = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check1("acc_step", 48'd3 * i, 1'b0);
        end

        ce_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("ce_p_hold", 48'd15, 1'b0);
        end
        ce_p = 1'b1;
        tick();
        check1("ce_p_resume", 48'd18, 1'b0);

        // Async reset between edges; the opmode register is cleared as well,
        // so the first edge after release reloads opmode and adds nothing.
        #2; rst = 1'b1; #1;
        check1("rst_async_mid", 48'd0, 1'b0);
        check0("rst_async_mid", 48'd0, 1'b0);
        rst = 1'b0;
        tick();
        check1("post_rst_edge1", 48'd0, 1'b0);
        tick();
        check1("post_rst_edge2", 48'd3, 1'b0);
        tick();
        check1("post_rst_edge3", 48'd6, 1'b0);

        // Accumulator wraps past 2^48.
        opmode = 5'b01100; c_in = 48'hFFFF_FFFF_FFFE;
        tick(); tick();
        check1("load_big", 48'hFFFF_FFFF_FFFE, 1'b0);
        opmode = 5'b01001; m_in = 36'd3;
        tick();
        check1("wrap_opm_load", 48'hFFFF_FFFF_FFFE, 1'b0);
        tick();
        check1("acc_wrap", 48'd1, 1'b1);

        // PREG=0: every P feedback selection contributes zero.
        opmode = 5'b00010; carryin = 1'b0;
        tick();
        check0("fb_x_only", 48'd0, 1'b0);
        opmode = 5'b01010;
        tick();
        check0("fb_x_z", 48'd0, 1'b0);
        carryin = 1'b1;
        tick();
        check0("fb_cin", 48'd1, 1'b0);
        opmode = 5'b11010;
        tick();
        check0("fb_sub_cin", 48'hFFFF_FFFF_FFFF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
